// File: rtl/key_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : key_encoder
//  Purpose  : Registered 8-to-3 priority encoder for the active-low push-button
//             bank. Raw key lines are sampled and debounced, and the result is
//             priority-encoded. Every debounced press is queued as a key-index
//             event in a first-word-fallthrough FIFO, which is drained through a
//             valid/ready handshake.
//  Ports    : clk       - clock, all state changes on posedge
//             rst       - synchronous active-high reset
//             enable    - block active only when enable == 3'd4
//             key_n     - raw key lines, active-low, bit 7 highest priority
//             code      - highest pressed debounced key index (registered)
//             any_n     - active-low "some debounced key pressed" (registered)
//             ev_valid  - event FIFO non-empty
//             ev_code   - key index at FIFO head, 3'd0 when empty
//             ev_ready  - consumer accepts head when ev_valid & ev_ready
//             overflow  - sticky flag, a press event was dropped on a full FIFO
//  Revision : 1.0 - initial release
// ============================================================================
module key_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] enable,
    input  logic [7:0] key_n,
    output logic [2:0] code,
    output logic       any_n,
    output logic       ev_valid,
    output logic [2:0] ev_code,
    input  logic       ev_ready,
    output logic       overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0]       c_cnt_last = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       c_en_code  = 3'd4;

    // ------------------------------------------------------------------------
    // Input capture and per-key debounce
    // ------------------------------------------------------------------------
    logic [7:0] r_key_q;
    logic [7:0] r_stable;
    logic [7:0] r_stable_d;   // previous stable value, used to spot press edges
    logic [7:0] r_cnt [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_q    <= 8'hff;
            r_stable   <= 8'hff;
            r_stable_d <= 8'hff;
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= 8'd0;
            end
        end else begin
            r_key_q    <= key_n;
            r_stable_d <= r_stable;
            for (int i = 0; i < 8; i++) begin
                if (r_key_q[i] == r_stable[i]) begin
                    r_cnt[i] <= 8'd0;
                end else if (r_cnt[i] == c_cnt_last) begin
                    // This edge would make the count reach DEBOUNCE_CYCLES.
                    r_stable[i] <= r_key_q[i];
                    r_cnt[i]    <= 8'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Priority encoding of the level and of the press edges
    // ------------------------------------------------------------------------
    logic       w_en;
    logic [7:0] w_fall;
    logic [2:0] w_hi;
    logic       w_any;
    logic [2:0] w_push_code;
    logic       w_push;

    assign w_en   = (enable == c_en_code);
    // A press edge is seen the cycle after stable falls, so the event is
    // written on the same edge that code/any_n reflect the new key.
    assign w_fall = r_stable_d & ~r_stable;

    always_comb begin
        w_hi        = 3'd0;
        w_any       = 1'b0;
        w_push_code = 3'd0;
        w_push      = 1'b0;
        // Ascending scan, so the last hit wins and bit 7 has the top priority.
        for (int i = 0; i < 8; i++) begin
            if (!r_stable[i]) begin
                w_hi  = 3'(i);
                w_any = 1'b1;
            end
            if (w_fall[i]) begin
                w_push_code = 3'(i);
                w_push      = w_en;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code  <= 3'd0;
            any_n <= 1'b1;
        end else if (w_en) begin
            code  <= w_hi;
            any_n <= ~w_any;
        end else begin
            code  <= 3'd0;
            any_n <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Event FIFO, first-word-fallthrough
    // ------------------------------------------------------------------------
    logic [2:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = ~w_empty & ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ev_valid = ~w_empty;
    assign ev_code  = w_empty ? 3'd0 : r_mem[r_rd_ptr];
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_encoder
//  Purpose  : Directed self-checking bench for key_encoder with default
//             parameters (DEBOUNCE_CYCLES = 4, FIFO_DEPTH = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_encoder;

    logic       clk;
    logic       rst;
    logic [2:0] enable;
    logic [7:0] key_n;
    logic [2:0] code;
    logic       any_n;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic       ev_ready;
    logic       overflow;

    int n_vec;
    int n_err;

    key_encoder #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .key_n   (key_n),
        .code    (code),
        .any_n   (any_n),
        .ev_valid(ev_valid),
        .ev_code (ev_code),
        .ev_ready(ev_ready),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges; inputs are driven and outputs sampled 1 time unit after.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        enable   = 3'd4;
        key_n    = 8'hff;
        ev_ready = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);

        // Reset / idle
        chk("rst_code",     code,     0);
        chk("rst_any_n",    any_n,    1);
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_code",  ev_code,  0);
        chk("rst_overflow", overflow, 0);

        // Key 5 held: captured at the first edge, outputs move 5 edges later
        key_n = 8'b1101_1111;
        step(5);
        chk("k5_any_n_early",    any_n,    1);
        chk("k5_ev_valid_early", ev_valid, 0);
        step(1);
        chk("k5_code",     code,     5);
        chk("k5_any_n",    any_n,    0);
        chk("k5_ev_valid", ev_valid, 1);
        chk("k5_ev_code",  ev_code,  5);
        step(4);
        key_n = 8'hff;
        step(5);
        chk("k5_rel_any_n_early", any_n, 0);
        step(1);
        chk("k5_rel_any_n",   any_n,    1);
        chk("k5_rel_ev_code", ev_code,  5);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        chk("k5_single_event", ev_valid, 0);

        // Three-cycle glitch on key 3 is rejected
        key_n = 8'b1111_0111;
        step(3);
        key_n = 8'hff;
        step(8);
        chk("glitch_code",     code,     0);
        chk("glitch_any_n",    any_n,    1);
        chk("glitch_ev_valid", ev_valid, 0);

        // Keys 2 and 6 together: one event, code 6, then 2 after releasing 6
        key_n = 8'b1011_1011;
        step(6);
        chk("k26_code",     code,     6);
        chk("k26_any_n",    any_n,    0);
        chk("k26_ev_valid", ev_valid, 1);
        chk("k26_ev_code",  ev_code,  6);
        key_n = 8'b1111_1011;
        step(6);
        chk("k2_code",    code,    2);
        chk("k2_ev_code", ev_code, 6);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        chk("k26_single_event", ev_valid, 0);
        key_n = 8'hff;
        step(6);
        chk("k26_rel_any_n", any_n, 1);

        // Five presses into a four-entry FIFO with no consumer
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                chk("ovf_before_5th", overflow, 0);
            end
            key_n = ~(8'h01 << k);
            step(6);
            key_n = 8'hff;
            step(6);
        end
        chk("ovf_set",      overflow, 1);
        chk("ovf_ev_valid", ev_valid, 1);
        ev_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain_%0d", j), ev_code, j);
            step(1);
        end
        ev_ready = 1'b0;
        chk("drain_empty",   ev_valid, 0);
        chk("drain_ev_code", ev_code,  0);
        chk("ovf_sticky",    overflow, 1);

        // Disabled while key 7 held, then re-enabled
        enable = 3'd5;
        key_n  = 8'b0111_1111;
        step(8);
        chk("dis_code",     code,     0);
        chk("dis_any_n",    any_n,    1);
        chk("dis_ev_valid", ev_valid, 0);
        enable = 3'd4;
        step(1);
        chk("reen_code",  code,  7);
        chk("reen_any_n", any_n, 0);
        step(3);
        chk("reen_no_event", ev_valid, 0);

        // Queue one event (key 1) and reset with the FIFO non-empty
        key_n = 8'hff;
        step(6);
        key_n = 8'b1111_1101;
        step(6);
        chk("pre_rst_ev_valid", ev_valid, 1);
        chk("pre_rst_ev_code",  ev_code,  1);
        chk("pre_rst_overflow", overflow, 1);
        rst = 1'b1;
        step(1);
        chk("post_rst_code",     code,     0);
        chk("post_rst_any_n",    any_n,    1);
        chk("post_rst_ev_valid", ev_valid, 0);
        chk("post_rst_ev_code",  ev_code,  0);
        chk("post_rst_overflow", overflow, 0);
        rst   = 1'b0;
        key_n = 8'hff;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_encoder.md
# key_encoder

Registered 8-to-3 priority encoder for the board's push-button bank. It is the input-side counterpart of the 3-to-8 active-low LED decoder driver. Active-low key lines are sampled, debounced and priority-encoded into a 3-bit code. Each debounced key press is also queued as an event in a small FIFO that the control logic drains through a valid/ready handshake.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive differing samples required to accept a key level change (2..255)
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- enable  in  3  block active only when enable == 3'd4
- key_n  in  8  raw key lines, active-low (0 = pressed); bit 7 highest priority
- code  out  3  index of highest-priority debounced pressed key, registered
- any_n  out  1  active-low "some debounced key pressed", registered
- ev_valid  out  1  FIFO non-empty
- ev_code  out  3  key index at FIFO head; 3'd0 when empty
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- overflow  out  1  sticky: a press event was dropped because the FIFO was full

## Operation
- Input stage: key_q <= key_n every cycle, regardless of enable.
- Debounce, per key i, with stable[i] and counter cnt[i]:
  - If key_q[i] == stable[i]: cnt[i] <= 0.
  - Otherwise cnt[i] increments.
  - On the edge where cnt[i] would reach DEBOUNCE_CYCLES: stable[i] <= key_q[i] and cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles changes nothing.
- Debounce runs independently of enable.
- Encoding, registered every cycle:
  - Enabled (enable == 3'd4): code <= highest i with stable[i] == 0; any_n <= 0 if any stable bit is 0, else 1. With no key pressed: code <= 0, any_n <= 1.
  - Disabled (any other enable value): code <= 0, any_n <= 1.
- Press event: stable[i] transitions 1→0 on an edge while enable == 3'd4.
  - At most one event is generated per cycle.
  - If several keys' press edges coincide, only the highest index is pushed. The lower ones are discarded silently and do not set overflow.
  - Release edges (0→1) generate no event.
- FIFO:
  - First-word-fallthrough; ev_code is valid whenever ev_valid = 1.
  - Pop on ev_valid & ev_ready.
  - Push when not full; also push when full if a pop occurs in the same cycle (full + push + pop keeps the count at FIFO_DEPTH).
  - A push while full without a pop is dropped and sets overflow = 1 until rst.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; the count is held separately so full and empty are unambiguous.

## Timing
- Reset values (on the first posedge with rst = 1): key_q = 8'hff, stable = 8'hff, all cnt = 0, code = 0, any_n = 1, FIFO empty, ev_valid = 0, ev_code = 0, overflow = 0.
- rst has priority over all other activity. Asserting it mid-debounce or with a non-empty FIFO discards all state.
- Latency: let E0 be the first edge at which key_q captures a held press.
  - stable updates at E0 + DEBOUNCE_CYCLES.
  - code, any_n and the FIFO write update at E0 + DEBOUNCE_CYCLES + 1.
  - ev_valid rises after that same edge.
  - With the default of 4, outputs change 5 edges after E0.
- Release path: same latency to any_n = 1.
- Pop takes effect at the edge where ev_valid & ev_ready is high. The next entry, or empty, is visible after that edge.
- An enable change affects code/any_n at the next edge. A press edge that occurs while disabled is lost; it is not replayed on re-enable.

## Test plan
- Reset, then all keys released, enable = 4 → code = 0, any_n = 1, ev_valid = 0, overflow = 0.
- Hold key_n = 8'b1101_1111 (key 5) for 10 cycles, ev_ready = 0 → code = 5 and any_n = 0 exactly 5 edges after capture; ev_valid = 1, ev_code = 5. Release → any_n = 1 after 5 edges; no second event.
- Pulse key 3 low for 3 cycles (DEBOUNCE_CYCLES = 4) → code, any_n and FIFO unchanged.
- Press keys 2 and 6 simultaneously → code = 6; exactly one event (6) queued. Then release key 6 → code = 2; no new event.
- ev_ready = 0; press and release keys 0, 1, 2, 3, 4 sequentially (each held ≥6 cycles) → FIFO holds 0, 1, 2, 3; overflow = 1. Then ev_ready = 1 → ev_code sequence 0, 1, 2, 3, then ev_valid = 0; overflow stays 1 until rst.
- enable = 3'd5 while holding key 7 → code = 0, any_n = 1, no event. Switch to enable = 4 → code = 7 and any_n = 0 next edge; still no event. Assert rst with a non-empty FIFO → all outputs return to their reset values after that edge.
